video_timing_gen: RTL and testbench
===================================

// Module: video_timing_gen
// PURPOSE
//  Source end of the video stream interface: generates raster timing {D_sync,Vsync,Hsync}, {Vblank,Hblank},
//  pixel coordinates and a selectable test pattern. Drives downstream video processing blocks
//  (vid_rgb/vh_blank/dvh_sync consumers) and the HDMI output path. Runs on the pixel clock gated by cen_i.
// PARAMETERS
//  H_ACTIVE 1280 active pixels/line     | H_FP 110 | H_SYNC 40 | H_BP 220   (H_TOTAL = sum, 1650)
//  V_ACTIVE 720  active lines/frame     | V_FP 5   | V_SYNC 5  | V_BP 20    (V_TOTAL = sum, 750)
//  HS_POL 1'b1, VS_POL 1'b1             sync active level
//  SOLID_RGB 24'hFF_5A_43               colour for pattern 1
// PORTS
//  clk_i        in   1   pixel clock
//  rst_ni       in   1   reset, asynchronous, active-low
//  cen_i        in   1   video clock enable; all state advances only when high
//  run_i        in   1   level: 1 = generate frames, 0 = stop at end of current frame
//  pat_sel_i    in   2   0 colour bars, 1 solid SOLID_RGB, 2 grey ramp, 3 checkerboard
//  vh_blank_o   out  2   {Vblank, Hblank}
//  dvh_sync_o   out  3   {D_sync, Vsync, Hsync}; D_sync = active-pixel (data enable)
//  vid_rgb_o    out  24  R[23:16] G[15:8] B[7:0]
//  pix_x_o      out  16  horizontal counter of the presented pixel
//  pix_y_o      out  16  vertical counter of the presented pixel
//  sof_o        out  1   1 for the (0,0) pixel only
//  busy_o       out  1   1 in RUN or STOP
//  frame_cnt_o  out  16  completed frames, wraps 16'hFFFF -> 0
// BEHAVIOUR
//  - Reset/IDLE outputs: vh_blank_o=2'b11, Hsync=~HS_POL, Vsync=~VS_POL, D_sync=0, rgb=0, x=y=0, sof=0,
//    busy=0, frame_cnt=0 (frame_cnt held, not cleared, when returning to IDLE).
//  - FSM (advances on cen_i only): IDLE -(run_i)-> RUN; RUN -(!run_i)-> STOP;
//    STOP -(run_i)-> RUN (no break in raster); STOP -(last pixel of frame: h=H_TOTAL-1, v=V_TOTAL-1)-> IDLE.
//    RUN at last pixel of frame wraps to (0,0) and increments frame_cnt; STOP at same point also increments.
//  - Counters h 0..H_TOTAL-1, v 0..V_TOTAL-1; h wraps -> v increments; v wraps at V_TOTAL-1.
//    Line order: active [0,H_ACTIVE), FP, SYNC, BP. Frame order likewise on v.
//  - Hblank = h>=H_ACTIVE; Hsync active for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
//  - Vblank = v>=V_ACTIVE; Vsync active for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
//  - D_sync = !Hblank && !Vblank. rgb = 0 whenever D_sync=0.
//  - Latency: all outputs registered; outputs for counter (h,v) appear 1 cen cycle after counter holds it.
//    First cen cycle with run_i=1 in IDLE loads (0,0); next cen cycle presents (0,0) with sof_o=1.
//  - cen_i low: every register holds, outputs stable.
//  - Patterns: bars = 8 bars of BAR_W=H_ACTIVE/8 pixels (last bar absorbs remainder), order
//    white,yellow,cyan,green,magenta,red,blue,black (full-scale 8'hFF/8'h00), tracked with a bar
//    counter (no divider); ramp = {3{x[7:0]}}; checker = white if x[4]^y[4] else black.
//  - pat_sel_i sampled per pixel; a change mid-frame takes effect on the next presented pixel.
//  - rst_ni asserted mid-frame: all outputs to reset values asynchronously; restart only from IDLE.
// STRUCTURE
//  - video_pkg: typedef rgb_t [23:0], enum pat_e {PAT_BARS,PAT_SOLID,PAT_RAMP,PAT_CHECK},
//    enum vtg_state_e {VTG_IDLE,VTG_RUN,VTG_STOP}, bar colour constant array.
//  - One sub-module: vtg_pattern (coords + pat_sel -> rgb, combinational, registered in parent).
//  - Parent holds FSM, h/v counters, bar counter, sync/blank decode, frame counter.
// TESTING (small params: H 8/2/2/2 -> H_TOTAL 14; V 4/1/1/1 -> V_TOTAL 7; frame = 98 cen cycles)
//  1 Reset held, run_i=1 -> outputs at reset values; release -> sof_o at cen cycle 2, x=y=0, D_sync=1.
//  2 Free run 3 frames, cen_i=1 -> Hsync active at x=10,11 each line; Vsync lines y=5 only; D_sync count
//    = 32/frame; frame_cnt 0->3; sof_o period exactly 98.
//  3 cen_i toggled 1-of-3 -> identical output sequence to case 2 sampled on cen cycles; outputs held between.
//  4 run_i dropped at (3,2) -> frame completes through (13,6), busy_o falls, outputs idle; rerun at
//    STOP (5,5) -> no gap, next frame starts at (0,0) normally.
//  5 pat_sel=0, H_ACTIVE=8 -> pixel x=0 rgb FFFFFF, x=1 FFFF00, x=7 000000; pat_sel=1 -> FF5A43;
//    pat_sel=2 x=5 -> 050505; blanked pixels rgb=0 for all patterns.
//  6 frame_cnt preset by forcing to 16'hFFFF -> wraps to 0 at next frame end; async rst_ni mid-line
//    -> outputs reset without waiting for clk edge.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and constants for the video timing generator.
//   rgb_t       : 24-bit pixel, R[23:16] G[15:8] B[7:0]
//   pat_e       : test pattern selector encoding
//   vtg_state_e : raster FSM state, also exported on the debug port
//   vid_out_t   : bundle of every registered raster output
//   BAR_RGB     : colour-bar palette, left to right
package video_pkg;

  typedef logic [23:0] rgb_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_SOLID = 2'd1,
    PAT_RAMP  = 2'd2,
    PAT_CHECK = 2'd3
  } pat_e;

  typedef enum logic [1:0] {
    VTG_IDLE = 2'd0,
    VTG_RUN  = 2'd1,
    VTG_STOP = 2'd2
  } vtg_state_e;

  typedef struct packed {
    logic [1:0]  vh_blank;  // {Vblank, Hblank}
    logic [2:0]  dvh_sync;  // {D_sync, Vsync, Hsync}
    rgb_t        rgb;
    logic [15:0] x;
    logic [15:0] y;
    logic        sof;
    logic        busy;
  } vid_out_t;

  localparam rgb_t BAR_RGB [8] = '{
    24'hFF_FF_FF,  // white
    24'hFF_FF_00,  // yellow
    24'h00_FF_FF,  // cyan
    24'h00_FF_00,  // green
    24'hFF_00_FF,  // magenta
    24'hFF_00_00,  // red
    24'h00_00_FF,  // blue
    24'h00_00_00   // black
  };

endpackage

// File: rtl/vtg_pattern.sv
// Test pattern colour lookup. Purely combinational; the parent registers the
// result together with the rest of the raster outputs.
//   pat_sel_i  in  2   pattern select (pat_e encoding)
//   x_i, y_i   in  16  raster coordinates of the pixel being built
//   bar_idx_i  in  3   colour-bar index tracked by the parent's bar counter
//   rgb_o      out 24  pattern colour (not yet gated by data enable)
module vtg_pattern
  import video_pkg::*;
#(
  parameter rgb_t SOLID_RGB = 24'hFF_5A_43
) (
  input  logic [1:0]  pat_sel_i,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic [2:0]  bar_idx_i,
  output rgb_t        rgb_o
);

  // Only the ramp byte and the 16-pixel checker bit of each coordinate matter.
  logic unused_coord_bits;
  assign unused_coord_bits = ^{x_i[15:8], y_i[15:5], y_i[3:0]};

  always_comb begin
    rgb_o = '0;
    case (pat_e'(pat_sel_i))
      PAT_BARS:  rgb_o = BAR_RGB[bar_idx_i];
      PAT_SOLID: rgb_o = SOLID_RGB;
      PAT_RAMP:  rgb_o = {3{x_i[7:0]}};
      PAT_CHECK: rgb_o = (x_i[4] ^ y_i[4]) ? 24'hFF_FF_FF : 24'h00_00_00;
      default:   rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: h/v counters, sync/blank decode, test pattern and
// frame counter. Everything advances only on cycles with cen_i high. The
// stream has no backpressure: consumers take one pixel per cen cycle.
//   clk_i, rst_ni  pixel clock, asynchronous active-low reset
//   cen_i          clock enable
//   run_i          1 = generate frames, 0 = finish current frame then idle
//   pat_sel_i      test pattern select
//   vh_blank_o     {Vblank, Hblank}
//   dvh_sync_o     {D_sync, Vsync, Hsync}
//   vid_rgb_o      pixel colour, 0 outside the active area
//   pix_x_o/y_o    coordinates of the presented pixel
//   sof_o          high on the (0,0) pixel only
//   busy_o         high while presenting pixels (RUN or STOP)
//   frame_cnt_o    completed frames, wrapping
//   dbg_state_o    current FSM state
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter logic        HS_POL    = 1'b1,
  parameter logic        VS_POL    = 1'b1,
  parameter rgb_t        SOLID_RGB = 24'hFF_5A_43
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic        run_i,
  input  logic [1:0]  pat_sel_i,
  output logic [1:0]  vh_blank_o,
  output logic [2:0]  dvh_sync_o,
  output rgb_t        vid_rgb_o,
  output logic [15:0] pix_x_o,
  output logic [15:0] pix_y_o,
  output logic        sof_o,
  output logic        busy_o,
  output logic [15:0] frame_cnt_o,
  output vtg_state_e  dbg_state_o
);

  localparam logic [15:0] H_ACT_C    = 16'(H_ACTIVE);
  localparam logic [15:0] HS_START_C = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END_C   = 16'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [15:0] H_LAST_C   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_ACT_C    = 16'(V_ACTIVE);
  localparam logic [15:0] VS_START_C = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END_C   = 16'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [15:0] V_LAST_C   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] BAR_W_C    = 16'((H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1);

  localparam vid_out_t IDLE_OUT = '{
    vh_blank: 2'b11,
    dvh_sync: {1'b0, ~VS_POL, ~HS_POL},
    rgb:      24'h0,
    x:        16'h0,
    y:        16'h0,
    sof:      1'b0,
    busy:     1'b0
  };

  vtg_state_e  state_q, state_d;
  logic [15:0] h_q, v_q;
  logic [15:0] bar_pos_q;
  logic [2:0]  bar_idx_q;
  logic [15:0] frame_cnt_q;
  vid_out_t    out_q, out_d;

  logic h_blank, v_blank, hs_act, vs_act, de, last_pix;
  rgb_t pat_rgb;

  assign h_blank  = (h_q >= H_ACT_C);
  assign v_blank  = (v_q >= V_ACT_C);
  assign hs_act   = (h_q >= HS_START_C) && (h_q < HS_END_C);
  assign vs_act   = (v_q >= VS_START_C) && (v_q < VS_END_C);
  assign de       = !h_blank && !v_blank;
  assign last_pix = (h_q == H_LAST_C) && (v_q == V_LAST_C);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    state_q <= VTG_IDLE;
    else if (cen_i) state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  // STOP keeps the raster going; raising run_i again resumes without a gap,
  // otherwise the frame is finished and the generator parks in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      VTG_IDLE: if (run_i) state_d = VTG_RUN;
      VTG_RUN:  if (!run_i) state_d = VTG_STOP;
      VTG_STOP: begin
        if (run_i)         state_d = VTG_RUN;
        else if (last_pix) state_d = VTG_IDLE;
      end
      default:  state_d = VTG_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (registered below) ----------------
  always_comb begin
    out_d = IDLE_OUT;
    if (state_q != VTG_IDLE) begin
      out_d.vh_blank = {v_blank, h_blank};
      out_d.dvh_sync = {de, vs_act ? VS_POL : ~VS_POL, hs_act ? HS_POL : ~HS_POL};
      out_d.rgb      = de ? pat_rgb : 24'h0;
      out_d.x        = h_q;
      out_d.y        = v_q;
      out_d.sof      = (h_q == 16'd0) && (v_q == 16'd0);
      out_d.busy     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    out_q <= IDLE_OUT;
    else if (cen_i) out_q <= out_d;
  end

  // ---------------- raster and bar counters ----------------
  // IDLE holds the counters at (0,0), so the cycle that leaves IDLE is the
  // load cycle and (0,0) is presented on the following cen cycle.
  // The bar counter steps alongside h so no divide by BAR_W is needed; the
  // last bar simply keeps counting to absorb any remainder.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q       <= '0;
      v_q       <= '0;
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else if (cen_i) begin
      if (state_q == VTG_IDLE) begin
        h_q       <= '0;
        v_q       <= '0;
        bar_pos_q <= '0;
        bar_idx_q <= '0;
      end else if (h_q == H_LAST_C) begin
        h_q       <= '0;
        v_q       <= (v_q == V_LAST_C) ? 16'd0 : v_q + 16'd1;
        bar_pos_q <= '0;
        bar_idx_q <= '0;
      end else begin
        h_q <= h_q + 16'd1;
        if (!h_blank) begin
          if ((bar_pos_q == BAR_W_C - 16'd1) && (bar_idx_q != 3'd7)) begin
            bar_pos_q <= '0;
            bar_idx_q <= bar_idx_q + 3'd1;
          end else begin
            bar_pos_q <= bar_pos_q + 16'd1;
          end
        end
      end
    end
  end

  // Counts on the edge that presents the last pixel, from RUN or STOP.
  // Deliberately not cleared on the way back to IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                     frame_cnt_q <= '0;
    else if (cen_i && state_q != VTG_IDLE && last_pix) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  vtg_pattern #(
    .SOLID_RGB (SOLID_RGB)
  ) u_pattern (
    .pat_sel_i (pat_sel_i),
    .x_i       (h_q),
    .y_i       (v_q),
    .bar_idx_i (bar_idx_q),
    .rgb_o     (pat_rgb)
  );

  assign vh_blank_o  = out_q.vh_blank;
  assign dvh_sync_o  = out_q.dvh_sync;
  assign vid_rgb_o   = out_q.rgb;
  assign pix_x_o     = out_q.x;
  assign pix_y_o     = out_q.y;
  assign sof_o       = out_q.sof;
  assign busy_o      = out_q.busy;
  assign frame_cnt_o = frame_cnt_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a small raster:
// H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), 98 pixels per frame.
module tb_video_timing_gen;
  import video_pkg::*;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int BAR_W = 1;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cen_i = 1'b1;
  logic        run_i = 1'b1;
  logic [1:0]  pat_sel_i = 2'd0;
  logic [1:0]  vh_blank_o;
  logic [2:0]  dvh_sync_o;
  rgb_t        vid_rgb_o;
  logic [15:0] pix_x_o, pix_y_o, frame_cnt_o;
  logic        sof_o, busy_o;
  vtg_state_e  dbg_state_o;

  always #5 clk_i = ~clk_i;

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .SOLID_RGB(24'hFF5A43)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cen_i(cen_i), .run_i(run_i),
    .pat_sel_i(pat_sel_i), .vh_blank_o(vh_blank_o), .dvh_sync_o(dvh_sync_o),
    .vid_rgb_o(vid_rgb_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o), .sof_o(sof_o),
    .busy_o(busy_o), .frame_cnt_o(frame_cnt_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int exp_x = 0;
  int exp_y = 0;
  logic [15:0] exp_frames = 16'd0;
  rgb_t bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- driver / model tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Next presented coordinate; a frame is counted as the last pixel is shown.
  task automatic model_adv();
    if (exp_x == HT - 1) begin
      exp_x = 0;
      exp_y = (exp_y == VT - 1) ? 0 : exp_y + 1;
    end else begin
      exp_x = exp_x + 1;
    end
    if (exp_x == HT - 1 && exp_y == VT - 1) exp_frames = exp_frames + 16'd1;
  endtask

  function automatic logic [2:0] exp_dvh(int x, int y);
    return {(x < 8 && y < 4), (y == 5), (x == 10 || x == 11)};
  endfunction

  function automatic logic [1:0] exp_vhb(int x, int y);
    return {(y >= 4), (x >= 8)};
  endfunction

  function automatic rgb_t exp_rgb(int x, int y, logic [1:0] pat);
    logic [7:0] xb;
    int bi;
    xb = x[7:0];
    bi = (x / BAR_W > 7) ? 7 : x / BAR_W;
    if (x >= 8 || y >= 4) return 24'h0;
    case (pat)
      2'd0:    return bar_tab[bi];
      2'd1:    return 24'hFF5A43;
      2'd2:    return {xb, xb, xb};
      default: return (((x >> 4) ^ (y >> 4)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
    endcase
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_ni = 1'b0; run_i = 1'b1; cen_i = 1'b1; pat_sel_i = 2'd0;
    repeat (3) tick();
    total++; if (vh_blank_o !== 2'b11) begin bad++; $display("FAIL rst_vhb got=%b exp=11", vh_blank_o); end
    total++; if (dvh_sync_o !== 3'b000) begin bad++; $display("FAIL rst_dvh got=%b exp=000", dvh_sync_o); end
    total++; if (vid_rgb_o !== 24'h0) begin bad++; $display("FAIL rst_rgb got=%h exp=0", vid_rgb_o); end
    total++; if (pix_x_o !== 16'd0 || pix_y_o !== 16'd0) begin bad++; $display("FAIL rst_xy got=%0d,%0d exp=0,0", pix_x_o, pix_y_o); end
    total++; if (sof_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL rst_sof_busy got=%b%b exp=00", sof_o, busy_o); end
    total++; if (frame_cnt_o !== 16'd0) begin bad++; $display("FAIL rst_frames got=%0d exp=0", frame_cnt_o); end
    rst_ni = 1'b1;
    tick();  // load cycle
    total++; if (sof_o !== 1'b0 || busy_o !== 1'b0) begin bad++; $display("FAIL load_cycle sof/busy got=%b%b exp=00", sof_o, busy_o); end
    tick();  // (0,0) presented
    total++; if (sof_o !== 1'b1) begin bad++; $display("FAIL first_sof got=%b exp=1", sof_o); end
    total++; if (pix_x_o !== 16'd0 || pix_y_o !== 16'd0) begin bad++; $display("FAIL first_xy got=%0d,%0d exp=0,0", pix_x_o, pix_y_o); end
    total++; if (dvh_sync_o !== 3'b100) begin bad++; $display("FAIL first_dvh got=%b exp=100", dvh_sync_o); end
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL first_busy got=%b exp=1", busy_o); end
    exp_x = 0; exp_y = 0; exp_frames = 16'd0;
  endtask

  task automatic test_free_run();
    int de_cnt, last_sof, sof_seen;
    de_cnt = 1;  // (0,0) of the first frame is already on the outputs
    last_sof = 0; sof_seen = 0;
    for (int c = 1; c <= 3 * HT * VT; c++) begin
      tick(); model_adv();
      total++; if (pix_x_o !== 16'(exp_x) || pix_y_o !== 16'(exp_y)) begin bad++; $display("FAIL run_xy got=%0d,%0d exp=%0d,%0d", pix_x_o, pix_y_o, exp_x, exp_y); end
      total++; if (dvh_sync_o !== exp_dvh(exp_x, exp_y)) begin bad++; $display("FAIL run_dvh at %0d,%0d got=%b exp=%b", exp_x, exp_y, dvh_sync_o, exp_dvh(exp_x, exp_y)); end
      total++; if (vh_blank_o !== exp_vhb(exp_x, exp_y)) begin bad++; $display("FAIL run_vhb at %0d,%0d got=%b exp=%b", exp_x, exp_y, vh_blank_o, exp_vhb(exp_x, exp_y)); end
      total++; if (sof_o !== (exp_x == 0 && exp_y == 0)) begin bad++; $display("FAIL run_sof at %0d,%0d got=%b", exp_x, exp_y, sof_o); end
      total++; if (frame_cnt_o !== exp_frames) begin bad++; $display("FAIL run_frames got=%0d exp=%0d", frame_cnt_o, exp_frames); end
      if (dvh_sync_o[2] === 1'b1) de_cnt++;
      if (sof_o === 1'b1) begin
        sof_seen++;
        total++; if (c - last_sof != HT * VT) begin bad++; $display("FAIL sof_period got=%0d exp=98", c - last_sof); end
        last_sof = c;
      end
      if (exp_x == HT - 1 && exp_y == VT - 1) begin
        total++; if (de_cnt != 32) begin bad++; $display("FAIL de_per_frame got=%0d exp=32", de_cnt); end
        de_cnt = 0;
      end
    end
    total++; if (sof_seen != 3) begin bad++; $display("FAIL sof_count got=%0d exp=3", sof_seen); end
    total++; if (frame_cnt_o !== 16'd3) begin bad++; $display("FAIL frames_after_3 got=%0d exp=3", frame_cnt_o); end
  endtask

  task automatic test_cen_gating();
    for (int c = 0; c < HT * VT; c++) begin
      cen_i = 1'b1;
      tick(); model_adv();
      cen_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
        total++; if (pix_x_o !== 16'(exp_x) || pix_y_o !== 16'(exp_y)) begin bad++; $display("FAIL cen_xy k=%0d got=%0d,%0d exp=%0d,%0d", k, pix_x_o, pix_y_o, exp_x, exp_y); end
        total++; if (dvh_sync_o !== exp_dvh(exp_x, exp_y)) begin bad++; $display("FAIL cen_dvh k=%0d got=%b exp=%b", k, dvh_sync_o, exp_dvh(exp_x, exp_y)); end
        total++; if (sof_o !== (exp_x == 0 && exp_y == 0) || frame_cnt_o !== exp_frames) begin bad++; $display("FAIL cen_sof_frames k=%0d got=%b/%0d exp frames=%0d", k, sof_o, frame_cnt_o, exp_frames); end
        if (k < 2) tick();
      end
    end
    cen_i = 1'b1;
    total++; if (frame_cnt_o !== 16'd4) begin bad++; $display("FAIL cen_frames got=%0d exp=4", frame_cnt_o); end
  endtask

  task automatic test_stop_restart();
    for (int k = 0; k < 200 && !(exp_x == 3 && exp_y == 2); k++) begin tick(); model_adv(); end
    run_i = 1'b0;
    for (int k = 0; k < 200 && !(exp_x == HT - 1 && exp_y == VT - 1); k++) begin
      tick(); model_adv();
      total++; if (busy_o !== 1'b1 || pix_x_o !== 16'(exp_x) || pix_y_o !== 16'(exp_y)) begin bad++; $display("FAIL stop_drain got=%b %0d,%0d exp=1 %0d,%0d", busy_o, pix_x_o, pix_y_o, exp_x, exp_y); end
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (busy_o !== 1'b0 || vh_blank_o !== 2'b11 || dvh_sync_o !== 3'b000) begin bad++; $display("FAIL idle_out busy=%b vhb=%b dvh=%b exp 0/11/000", busy_o, vh_blank_o, dvh_sync_o); end
      total++; if (pix_x_o !== 16'd0 || pix_y_o !== 16'd0 || vid_rgb_o !== 24'h0 || sof_o !== 1'b0) begin bad++; $display("FAIL idle_data got=%0d,%0d %h %b", pix_x_o, pix_y_o, vid_rgb_o, sof_o); end
      total++; if (dbg_state_o !== VTG_IDLE || frame_cnt_o !== 16'd5) begin bad++; $display("FAIL idle_state got=%0d frames=%0d exp=0 5", dbg_state_o, frame_cnt_o); end
    end
    run_i = 1'b1;
    tick();
    total++; if (busy_o !== 1'b0 || sof_o !== 1'b0) begin bad++; $display("FAIL rerun_load got=%b%b exp=00", busy_o, sof_o); end
    tick();
    exp_x = 0; exp_y = 0;
    total++; if (sof_o !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("FAIL rerun_sof got=%b%b exp=11", sof_o, busy_o); end
    for (int k = 0; k < 200 && !(exp_x == 0 && exp_y == 1); k++) begin tick(); model_adv(); end
    run_i = 1'b0;
    for (int k = 0; k < 200 && !(exp_x == 5 && exp_y == 5); k++) begin tick(); model_adv(); end
    total++; if (dbg_state_o !== VTG_STOP) begin bad++; $display("FAIL stop_state got=%0d exp=%0d", dbg_state_o, VTG_STOP); end
    run_i = 1'b1;
    for (int k = 0; k < 200 && !(exp_x == 0 && exp_y == 0); k++) begin
      tick(); model_adv();
      total++; if (busy_o !== 1'b1 || pix_x_o !== 16'(exp_x) || pix_y_o !== 16'(exp_y)) begin bad++; $display("FAIL resume got=%b %0d,%0d exp=1 %0d,%0d", busy_o, pix_x_o, pix_y_o, exp_x, exp_y); end
    end
    total++; if (sof_o !== 1'b1 || frame_cnt_o !== 16'd6) begin bad++; $display("FAIL resume_sof got=%b frames=%0d exp=1 6", sof_o, frame_cnt_o); end
  endtask

  task automatic test_patterns();
    logic [1:0] pat;
    int ny;
    for (int c = 0; c < HT * VT; c++) begin
      ny = (exp_x == HT - 1) ? ((exp_y == VT - 1) ? 0 : exp_y + 1) : exp_y;
      pat = 2'(ny % 4);  // one pattern per line, all four across the active lines
      pat_sel_i = pat;
      tick(); model_adv();
      total++; if (vid_rgb_o !== exp_rgb(exp_x, exp_y, pat)) begin bad++; $display("FAIL pattern pat=%0d at %0d,%0d got=%h exp=%h", pat, exp_x, exp_y, vid_rgb_o, exp_rgb(exp_x, exp_y, pat)); end
    end
    pat_sel_i = 2'd0;
  endtask

  task automatic test_wrap_and_async_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    #2;
    release dut.frame_cnt_q;
    exp_frames = 16'hFFFF;
    total++; if (frame_cnt_o !== 16'hFFFF) begin bad++; $display("FAIL preset_frames got=%h exp=ffff", frame_cnt_o); end
    for (int k = 0; k < 200 && !(exp_x == HT - 1 && exp_y == VT - 1); k++) begin
      tick(); model_adv();
      total++; if (frame_cnt_o !== exp_frames) begin bad++; $display("FAIL wrap_frames got=%h exp=%h", frame_cnt_o, exp_frames); end
    end
    total++; if (frame_cnt_o !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h exp=0000", frame_cnt_o); end
    for (int k = 0; k < 200 && !(exp_x == 4 && exp_y == 1); k++) begin tick(); model_adv(); end
    rst_ni = 1'b0;
    #2;  // still between clock edges
    total++; if (vh_blank_o !== 2'b11 || dvh_sync_o !== 3'b000 || vid_rgb_o !== 24'h0) begin bad++; $display("FAIL async_vid got=%b %b %h", vh_blank_o, dvh_sync_o, vid_rgb_o); end
    total++; if (pix_x_o !== 16'd0 || pix_y_o !== 16'd0 || busy_o !== 1'b0 || sof_o !== 1'b0) begin bad++; $display("FAIL async_xy got=%0d,%0d busy=%b sof=%b", pix_x_o, pix_y_o, busy_o, sof_o); end
    total++; if (frame_cnt_o !== 16'd0 || dbg_state_o !== VTG_IDLE) begin bad++; $display("FAIL async_state frames=%0d state=%0d", frame_cnt_o, dbg_state_o); end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL post_rst_load busy=%b exp=0", busy_o); end
    tick();
    total++; if (sof_o !== 1'b1 || pix_x_o !== 16'd0 || pix_y_o !== 16'd0) begin bad++; $display("FAIL post_rst_sof got=%b %0d,%0d", sof_o, pix_x_o, pix_y_o); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_cen_gating();
    test_stop_restart();
    test_patterns();
    test_wrap_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
